// File: rtl/cv32e40p_pkg.sv
// Shared types for the cv32e40p prefetch path.
// Fetch FSM states and word-address helpers.
package cv32e40p_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } fetch_state_e;

    localparam logic [31:0] INSTR_STEP = 32'd4;

    function automatic logic [31:0] word_addr(input logic [29:0] w);
        return {w, 2'b00};
    endfunction

endpackage

// File: rtl/cv32e40p_fetch_filler.sv
// Prefetch FIFO filler: issues sequential OBI fetches against FIFO credit,
// pushes responses, and flushes/discards stale work on a branch.
module cv32e40p_fetch_filler
    import cv32e40p_pkg::*;
#(
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned MAX_OUT = 2,
    parameter int unsigned CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      boot_addr_i,
    input  logic             req_i,
    input  logic             branch_i,
    input  logic [31:0]      branch_addr_i,
    input  logic [CNT_W-1:0] fifo_cnt_i,
    output logic             fifo_push_o,
    output logic [31:0]      fifo_wdata_o,
    output logic             fifo_flush_o,
    output logic             instr_req_o,
    input  logic             instr_gnt_i,
    output logic [31:0]      instr_addr_o,
    input  logic             instr_rvalid_i,
    input  logic [31:0]      instr_rdata_i,
    output logic             busy_o
);

    localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);
    localparam int unsigned SUM_W =
        ((OUT_W > CNT_W) ? OUT_W : CNT_W) + 1;

    fetch_state_e     state_q, state_d;
    logic [31:0]      fetch_addr_q, fetch_addr_d;
    logic [31:0]      hold_addr_q, hold_addr_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic [OUT_W-1:0] discard_q, discard_d;
    logic             stale_q, stale_d;

    logic             can_issue;
    logic             gnt;
    logic             drop;
    logic [SUM_W-1:0] used;

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{boot_addr_i[1:0], branch_addr_i[1:0]};

    // Credit check and bus-side request/address selection.
    always_comb begin
        used = SUM_W'(out_q - discard_q) + SUM_W'(fifo_cnt_i);
        can_issue = req_i & ~branch_i
                  & (out_q < OUT_W'(MAX_OUT))
                  & (used < SUM_W'(DEPTH));
        instr_req_o  = can_issue;
        instr_addr_o = fetch_addr_q;
        if (state_q == HOLD) begin
            instr_req_o  = 1'b1;
            instr_addr_o = hold_addr_q;
        end
        gnt  = instr_req_o & instr_gnt_i;
        drop = instr_rvalid_i & (discard_q != '0);
    end

    assign fifo_push_o  = instr_rvalid_i & (discard_q == '0) & ~branch_i;
    assign fifo_wdata_o = instr_rdata_i;
    assign fifo_flush_o = branch_i;
    assign busy_o       = (out_q != '0) | (state_q == HOLD);

    // Next-state: FSM, fetch address, outstanding and discard tracking.
    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        hold_addr_d  = hold_addr_q;
        stale_d      = stale_q;
        out_d        = out_q + OUT_W'(gnt) - OUT_W'(instr_rvalid_i);
        discard_d    = discard_q - OUT_W'(drop)
                     + OUT_W'(gnt & stale_q);

        unique case (state_q)
            IDLE: begin
                if (instr_req_o && !instr_gnt_i) begin
                    state_d     = HOLD;
                    hold_addr_d = fetch_addr_q;
                end
            end
            HOLD: begin
                if (instr_gnt_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (gnt && !stale_q) fetch_addr_d = fetch_addr_q + INSTR_STEP;
        if (gnt) stale_d = 1'b0;

        // A branch counts everything still in flight after this cycle;
        // a held, ungranted request is accounted when its grant arrives.
        if (branch_i) begin
            fetch_addr_d = word_addr(branch_addr_i[31:2]);
            discard_d    = out_d;
            stale_d      = (state_q == HOLD) & ~instr_gnt_i;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            fetch_addr_q <= word_addr(boot_addr_i[31:2]);
            hold_addr_q  <= '0;
            out_q        <= '0;
            discard_q    <= '0;
            stale_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            hold_addr_q  <= hold_addr_d;
            out_q        <= out_d;
            discard_q    <= discard_d;
            stale_q      <= stale_d;
        end
    end

`ifndef SYNTHESIS
    // A response with nothing outstanding breaks the OBI protocol.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(instr_rvalid_i && out_q == '0))
            else $error("rvalid with no outstanding transaction");
        end
    end
`endif

endmodule

// File: tb/tb_cv32e40p_fetch_filler.sv
// Directed bench for cv32e40p_fetch_filler.
// Environment keeps a FIFO occupancy count fed back as fifo_cnt_i.
module tb_cv32e40p_fetch_filler;

    logic        clk;
    logic        rst;
    logic [31:0] boot;
    logic        req;
    logic        br;
    logic [31:0] br_addr;
    logic [1:0]  cnt;
    logic        push;
    logic [31:0] wdata;
    logic        flush;
    logic        ireq;
    logic        gnt;
    logic [31:0] iaddr;
    logic        rvalid;
    logic [31:0] rdata;
    logic        busy;
    logic        pop;

    int vectors;
    int errs;

    cv32e40p_fetch_filler #(.DEPTH(2), .MAX_OUT(2)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .boot_addr_i    (boot),
        .req_i          (req),
        .branch_i       (br),
        .branch_addr_i  (br_addr),
        .fifo_cnt_i     (cnt),
        .fifo_push_o    (push),
        .fifo_wdata_o   (wdata),
        .fifo_flush_o   (flush),
        .instr_req_o    (ireq),
        .instr_gnt_i    (gnt),
        .instr_addr_o   (iaddr),
        .instr_rvalid_i (rvalid),
        .instr_rdata_i  (rdata),
        .busy_o         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst || flush) cnt <= 2'd0;
        else cnt <= cnt + 2'(push) - 2'(pop);
    end

    task automatic chk32(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic r, input logic g, input logic rv,
                       input logic [31:0] rd, input logic p);
        req = r; gnt = g; rvalid = rv; rdata = rd; pop = p; br = 1'b0;
    endtask

    task automatic nxt;
        @(negedge clk);
    endtask

    initial begin
        vectors = 0; errs = 0;
        rst = 1'b1; boot = 32'h8000_0003; br_addr = '0;
        drv(0, 0, 0, 32'h0, 0);
        cnt = 2'd0;
        nxt(); nxt();
        #1;
        chk32("rst_addr", iaddr, 32'h8000_0000);
        chk1("rst_req", ireq, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_push", push, 1'b0);
        chk1("rst_flush", flush, 1'b0);

        // Sequential fetch from boot address, gnt always high.
        nxt(); rst = 1'b0; drv(1, 1, 0, 32'h0, 0); #1;
        chk1("seq0_req", ireq, 1'b1);
        chk32("seq0_addr", iaddr, 32'h8000_0000);
        nxt(); drv(1, 1, 1, 32'hD000_0000, 0); #1;
        chk1("seq1_req", ireq, 1'b1);
        chk32("seq1_addr", iaddr, 32'h8000_0004);
        chk1("seq1_push", push, 1'b1);
        chk32("seq1_wdata", wdata, 32'hD000_0000);
        chk1("seq1_busy", busy, 1'b1);
        nxt(); drv(1, 1, 1, 32'hD000_0001, 0); #1;
        chk1("seq2_nocredit", ireq, 1'b0);
        chk1("seq2_push", push, 1'b1);
        // FIFO full, no pops.
        nxt(); drv(1, 1, 0, 32'h0, 0); #1;
        chk1("full0_req", ireq, 1'b0);
        chk1("full0_cnt", cnt <= 2'd2, 1'b1);
        chk32("full0_cntv", {30'd0, cnt}, 32'd2);
        chk1("full0_busy", busy, 1'b0);
        nxt(); drv(1, 1, 0, 32'h0, 1); #1;
        chk1("full1_req", ireq, 1'b0);
        nxt(); drv(1, 1, 0, 32'h0, 0); #1;
        chk1("pop_req", ireq, 1'b1);
        chk32("pop_addr", iaddr, 32'h8000_0008);
        nxt(); drv(1, 1, 0, 32'h0, 0); #1;
        chk1("pop_onlyone", ireq, 1'b0);
        nxt(); drv(1, 1, 1, 32'hD000_0002, 0); #1;
        chk1("pop_resp_push", push, 1'b1);
        chk1("pop_resp_req", ireq, 1'b0);
        nxt(); drv(0, 0, 0, 32'h0, 1);
        nxt(); drv(0, 0, 0, 32'h0, 1);

        // Held request with a branch while waiting for grant.
        nxt(); drv(1, 0, 0, 32'h0, 0); #1;
        chk1("hold0_req", ireq, 1'b1);
        chk32("hold0_addr", iaddr, 32'h8000_000C);
        nxt(); drv(1, 0, 0, 32'h0, 0); br = 1'b1; br_addr = 32'h100; #1;
        chk1("hold1_req", ireq, 1'b1);
        chk32("hold1_addr", iaddr, 32'h8000_000C);
        chk1("hold1_flush", flush, 1'b1);
        chk1("hold1_busy", busy, 1'b1);
        nxt(); drv(0, 0, 0, 32'h0, 0); #1;
        chk1("hold2_req", ireq, 1'b1);
        chk32("hold2_addr", iaddr, 32'h8000_000C);
        chk1("hold2_flush", flush, 1'b0);
        nxt(); drv(0, 1, 0, 32'h0, 0); #1;
        chk32("hold3_addr", iaddr, 32'h8000_000C);
        nxt(); drv(1, 1, 1, 32'hDEAD_BEEF, 0); #1;
        chk1("stale_drop", push, 1'b0);
        chk1("tgt_req", ireq, 1'b1);
        chk32("tgt_addr", iaddr, 32'h0000_0100);
        nxt(); drv(0, 0, 1, 32'h0000_1100, 0); #1;
        chk1("tgt_push", push, 1'b1);
        chk32("tgt_wdata", wdata, 32'h0000_1100);
        chk1("tgt_noreq", ireq, 1'b0);
        nxt(); drv(0, 0, 0, 32'h0, 1); #1;
        chk1("tgt_idle", busy, 1'b0);

        // Two outstanding, branch to 0x200, both responses dropped.
        nxt(); drv(1, 1, 0, 32'h0, 0); #1;
        chk32("two0_addr", iaddr, 32'h0000_0104);
        nxt(); drv(1, 1, 0, 32'h0, 0); #1;
        chk32("two1_addr", iaddr, 32'h0000_0108);
        nxt(); drv(1, 1, 0, 32'h0, 0); br = 1'b1; br_addr = 32'h200; #1;
        chk1("two_br_flush", flush, 1'b1);
        chk1("two_br_req", ireq, 1'b0);
        nxt(); drv(1, 0, 1, 32'h0000_0104, 0); #1;
        chk1("two_flush_once", flush, 1'b0);
        chk1("two_drop0", push, 1'b0);
        chk1("two_outmax", ireq, 1'b0);
        nxt(); drv(1, 1, 1, 32'h0000_0108, 0); #1;
        chk1("two_drop1", push, 1'b0);
        chk1("two_tgt_req", ireq, 1'b1);
        chk32("two_tgt_addr", iaddr, 32'h0000_0200);
        nxt(); drv(0, 0, 1, 32'h0000_2200, 0); #1;
        chk1("two_tgt_push", push, 1'b1);
        chk32("two_tgt_wdata", wdata, 32'h0000_2200);
        nxt(); drv(0, 0, 0, 32'h0, 1);

        // Branch coinciding with a held grant and a response.
        nxt(); drv(1, 1, 0, 32'h0, 0); #1;
        chk32("co0_addr", iaddr, 32'h0000_0204);
        nxt(); drv(1, 0, 0, 32'h0, 0); #1;
        chk32("co1_addr", iaddr, 32'h0000_0208);
        nxt(); drv(1, 1, 1, 32'h0000_0204, 0);
        br = 1'b1; br_addr = 32'h300; #1;
        chk1("co_br_req", ireq, 1'b1);
        chk32("co_br_addr", iaddr, 32'h0000_0208);
        chk1("co_br_nopush", push, 1'b0);
        chk1("co_br_flush", flush, 1'b1);
        nxt(); drv(1, 1, 1, 32'h0000_0208, 0); #1;
        chk1("co_drop", push, 1'b0);
        chk32("co_tgt_addr", iaddr, 32'h0000_0300);
        nxt(); drv(0, 0, 1, 32'h0000_3300, 0); #1;
        chk1("co_tgt_push", push, 1'b1);
        nxt(); drv(0, 0, 0, 32'h0, 1);

        // Address wrap and alignment of the branch target.
        nxt(); drv(0, 0, 0, 32'h0, 0); br = 1'b1; br_addr = 32'hFFFF_FFFF;
        nxt(); drv(1, 1, 0, 32'h0, 0); #1;
        chk32("wrap_addr", iaddr, 32'hFFFF_FFFC);
        nxt(); drv(0, 0, 1, 32'h1234_5678, 0); #1;
        chk32("wrap_next", iaddr, 32'h0000_0000);
        chk1("wrap_push", push, 1'b1);
        nxt(); drv(0, 0, 0, 32'h0, 1);
        nxt(); drv(0, 0, 0, 32'h0, 0); #1;
        chk1("end_busy", busy, 1'b0);
        chk32("end_cnt", {30'd0, cnt}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
